// File: rtl/fifo_rx_spram.sv
// Receive-side byte FIFO between the UART receiver and the CPU CSR port.
// A head register sits in front of a (Depth-1)-entry RAM so pops never see a bubble.
module fifo_rx_spram #(
   parameter int          Depth         = 16,
   parameter logic [11:0] RxByteCsrAddr = 12'h0B1,
   parameter logic [11:0] RxStatCsrAddr = 12'h0B2
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    rx_valid_i,
   input  logic [7:0]              rx_data_i,
   input  logic                    csr_enable,
   input  logic [11:0]             csr_addr,
   input  logic                    csr_write,
   input  logic [31:0]             rs1_data,
   output logic [31:0]             csr_data_out,
   output logic                    have_data,
   output logic [$clog2(Depth):0]  count,
   output logic                    irq
);

   localparam int PW    = $clog2(Depth);
   localparam int CW    = PW + 1;
   localparam int RAM_N = Depth - 1;

   logic [7:0]    r_mem [RAM_N];
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   logic [7:0]    r_head;
   logic          r_head_valid;
   logic          r_overrun;
   logic          r_irq_en;
   logic [7:0]    r_threshold;

   logic          w_sel_byte;
   logic          w_sel_stat;
   logic          w_stat_wr;
   logic          w_pop;
   logic          w_full;
   logic          w_push;
   logic          w_drop;
   logic          w_ram_has;
   logic          w_ram_rd;
   logic          w_ram_wr;
   logic          w_head_load_rx;
   logic [7:0]    w_thr_eff;
   logic          w_unused_bits;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(RAM_N - 1)) ? '0 : p + PW'(1);
   endfunction

   assign w_sel_byte = csr_enable & (csr_addr == RxByteCsrAddr);
   assign w_sel_stat = csr_enable & (csr_addr == RxStatCsrAddr);
   assign w_stat_wr  = w_sel_stat & csr_write;
   assign w_pop      = w_sel_byte & ~csr_write & r_head_valid;
   assign w_full     = (r_count == CW'(Depth));
   assign w_push     = rx_valid_i & (~w_full | w_pop);
   assign w_drop     = rx_valid_i & w_full & ~w_pop;
   assign w_ram_has  = (r_count > CW'(1));
   assign w_ram_rd   = w_pop & w_ram_has;

   // A push lands in the head directly when the head is empty or is being
   // drained with nothing behind it; this also covers read-during-write.
   assign w_ram_wr       = w_push & r_head_valid & ~(w_pop & ~w_ram_has);
   assign w_head_load_rx = w_push & ~w_ram_wr;

   assign w_unused_bits = ^{rs1_data[31:24], rs1_data[15:4], rs1_data[1:0]};

   always_ff @(posedge clk_i) begin
      if (w_ram_wr) begin
         r_mem[r_wr_ptr] <= rx_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_rd_ptr     <= '0;
         r_wr_ptr     <= '0;
         r_count      <= '0;
         r_head       <= '0;
         r_head_valid <= 1'b0;
      end else begin
         if (w_ram_rd) begin
            r_head       <= r_mem[r_rd_ptr];
            r_head_valid <= 1'b1;
            r_rd_ptr     <= ptr_inc(r_rd_ptr);
         end else if (w_head_load_rx) begin
            r_head       <= rx_data_i;
            r_head_valid <= 1'b1;
         end else if (w_pop) begin
            r_head_valid <= 1'b0;
         end
         if (w_ram_wr) begin
            r_wr_ptr <= ptr_inc(r_wr_ptr);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Overrun set has priority over a same-cycle W1C clear.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_overrun   <= 1'b0;
         r_irq_en    <= 1'b0;
         r_threshold <= 8'd1;
      end else begin
         if (w_drop) begin
            r_overrun <= 1'b1;
         end else if (w_stat_wr && rs1_data[2]) begin
            r_overrun <= 1'b0;
         end
         if (w_stat_wr) begin
            r_irq_en    <= rs1_data[3];
            r_threshold <= rs1_data[23:16];
         end
      end
   end

   assign w_thr_eff = (r_threshold == 8'd0) ? 8'd1 : r_threshold;
   assign irq       = r_irq_en & (9'(r_count) >= {1'b0, w_thr_eff});
   assign have_data = r_head_valid;
   assign count     = r_count;

   always_comb begin
      csr_data_out = 32'h0;
      if (w_sel_byte && r_head_valid) begin
         csr_data_out = {1'b1, 23'h0, r_head};
      end else if (w_sel_stat) begin
         csr_data_out = {8'h0, r_threshold, 8'(r_count), 4'h0,
                         r_irq_en, r_overrun, w_full, r_head_valid};
      end
   end

endmodule

// File: tb/tb_fifo_rx_spram.sv
// Directed plus randomized bench for fifo_rx_spram; expectations come from a
// byte-queue model of the receive FIFO and its CSR fields.
module tb_fifo_rx_spram;

   localparam int          DEPTH  = 16;
   localparam logic [11:0] A_BYTE = 12'h0B1;
   localparam logic [11:0] A_STAT = 12'h0B2;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        rx_valid_i;
   logic [7:0]  rx_data_i;
   logic        csr_enable;
   logic [11:0] csr_addr;
   logic        csr_write;
   logic [31:0] rs1_data;
   logic [31:0] csr_data_out;
   logic        have_data;
   logic [4:0]  count;
   logic        irq;

   always #5 clk_i = ~clk_i;

   fifo_rx_spram #(
      .Depth(DEPTH),
      .RxByteCsrAddr(A_BYTE),
      .RxStatCsrAddr(A_STAT)
   ) dut (
      .clk_i(clk_i),
      .reset_i(reset_i),
      .rx_valid_i(rx_valid_i),
      .rx_data_i(rx_data_i),
      .csr_enable(csr_enable),
      .csr_addr(csr_addr),
      .csr_write(csr_write),
      .rs1_data(rs1_data),
      .csr_data_out(csr_data_out),
      .have_data(have_data),
      .count(count),
      .irq(irq)
   );

   int          n_checks = 0;
   int          n_err    = 0;
   logic [7:0]  q[$];
   bit          m_ovr;
   bit          m_ien;
   bit [7:0]    m_thr;
   logic [31:0] last_csr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_ovr = 1'b0;
      m_ien = 1'b0;
      m_thr = 8'd1;
   endtask

   function automatic logic [31:0] model_csr(input bit en, input bit [11:0] a);
      if (!en) return 32'h0;
      if (a == A_BYTE) return (q.size() > 0) ? {1'b1, 23'h0, q[0]} : 32'h0;
      if (a == A_STAT)
         return {8'h0, m_thr, 8'(q.size()), 4'h0, m_ien, m_ovr,
                 (q.size() == DEPTH), (q.size() > 0)};
      return 32'h0;
   endfunction

   function automatic bit model_irq();
      int thr;
      thr = (m_thr == 8'd0) ? 1 : int'(m_thr);
      return m_ien && (q.size() >= thr);
   endfunction

   // Entered at a falling edge; leaves at the next falling edge.
   task automatic cyc(input bit push, input bit [7:0] d, input bit en,
                      input bit [11:0] a, input bit wr, input bit [31:0] wd);
      bit pop;
      bit drop;
      rx_valid_i = push;
      rx_data_i  = d;
      csr_enable = en;
      csr_addr   = a;
      csr_write  = wr;
      rs1_data   = wd;
      #1;
      last_csr = csr_data_out;
      chk("csr_data_out", csr_data_out, model_csr(en, a));
      @(posedge clk_i);
      pop  = en && (a == A_BYTE) && !wr && (q.size() > 0);
      drop = push && (q.size() == DEPTH) && !pop;
      if (pop) void'(q.pop_front());
      if (push && !drop) q.push_back(d);
      if (en && (a == A_STAT) && wr) begin
         m_ien = wd[3];
         m_thr = wd[23:16];
         if (wd[2]) m_ovr = 1'b0;
      end
      if (drop) m_ovr = 1'b1;
      @(negedge clk_i);
      rx_valid_i = 1'b0;
      csr_enable = 1'b0;
      csr_write  = 1'b0;
      chk("have_data", 32'(have_data), 32'(q.size() > 0));
      chk("count", 32'(count), 32'(q.size()));
      chk("irq", 32'(irq), 32'(model_irq()));
   endtask

   task automatic push_b(input bit [7:0] d);
      cyc(1'b1, d, 1'b0, 12'h0, 1'b0, 32'h0);
   endtask

   task automatic pop_rd();
      cyc(1'b0, 8'h0, 1'b1, A_BYTE, 1'b0, 32'h0);
   endtask

   task automatic stat_rd();
      cyc(1'b0, 8'h0, 1'b1, A_STAT, 1'b0, 32'h0);
   endtask

   task automatic stat_wr(input bit [31:0] wd);
      cyc(1'b0, 8'h0, 1'b1, A_STAT, 1'b1, wd);
   endtask

   initial begin
      int r;
      int pp;
      bit [31:0] wd;
      reset_i    = 1'b0;
      rx_valid_i = 1'b0;
      rx_data_i  = 8'h0;
      csr_enable = 1'b0;
      csr_addr   = 12'h0;
      csr_write  = 1'b0;
      rs1_data   = 32'h0;
      model_reset();
      repeat (3) @(negedge clk_i);
      reset_i = 1'b1;
      @(negedge clk_i);

      chk("rst_have_data", 32'(have_data), 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      chk("rst_count", 32'(count), 32'h0);
      stat_rd();
      chk("rst_status", last_csr, 32'h0001_0000);

      push_b(8'h41);
      pop_rd();
      chk("first_byte", last_csr, 32'h8000_0041);
      stat_rd();
      chk("status_after_pop", last_csr, 32'h0001_0000);

      for (int i = 0; i < 16; i++) push_b(8'(i));
      push_b(8'hFF);
      stat_rd();
      chk("full_overrun_status", last_csr, 32'h0001_1007);
      for (int i = 0; i < 16; i++) begin
         pop_rd();
         chk("drain_order", last_csr, 32'h8000_0000 | 32'(i));
      end
      pop_rd();
      chk("empty_read", last_csr, 32'h0);

      stat_wr(32'h0001_0004);
      for (int i = 0; i < 16; i++) push_b(8'(8'h20 + i));
      cyc(1'b1, 8'hAA, 1'b1, A_BYTE, 1'b0, 32'h0);
      chk("full_pushpop_head", last_csr, 32'h8000_0020);
      chk("full_pushpop_count", 32'(count), 32'd16);
      for (int i = 1; i < 16; i++) begin
         pop_rd();
         chk("full_pushpop_order", last_csr, 32'h8000_0020 + 32'(i));
      end
      pop_rd();
      chk("aa_last", last_csr, 32'h8000_00AA);
      chk("aa_count", 32'(count), 32'd0);

      stat_wr(32'h0004_0008);
      for (int i = 0; i < 3; i++) begin
         push_b(8'(8'h60 + i));
         chk("irq_below_thr", 32'(irq), 32'h0);
      end
      push_b(8'h63);
      chk("irq_at_thr", 32'(irq), 32'h1);
      pop_rd();
      chk("irq_after_pop", 32'(irq), 32'h0);

      for (int i = 0; i < 13; i++) push_b(8'(8'h70 + i));
      push_b(8'hEE);
      stat_wr(32'h0004_000C);
      stat_rd();
      chk("w1c_overrun", last_csr, 32'h0004_100B);
      cyc(1'b1, 8'h55, 1'b1, A_STAT, 1'b1, 32'h0004_000C);
      stat_rd();
      chk("overrun_set_wins", last_csr, 32'h0004_100F);
      for (int i = 0; i < 16; i++) pop_rd();

      for (int i = 0; i < 800; i++) begin
         pp = ((i / 100) % 2 == 0) ? 75 : 30;
         r  = $urandom_range(0, 99);
         wd = $urandom;
         if (r < 45)
            cyc($urandom_range(0, 99) < pp, 8'($urandom), 1'b1, A_BYTE, 1'b0, 32'h0);
         else if (r < 55)
            cyc($urandom_range(0, 99) < pp, 8'($urandom), 1'b1, A_STAT, 1'b0, 32'h0);
         else if (r < 60) begin
            wd[23:16] = 8'($urandom_range(0, 17));
            cyc($urandom_range(0, 99) < pp, 8'($urandom), 1'b1, A_STAT, 1'b1, wd);
         end else if (r < 65)
            cyc($urandom_range(0, 99) < pp, 8'($urandom), 1'b1, A_BYTE, 1'b1, wd);
         else if (r < 70)
            cyc($urandom_range(0, 99) < pp, 8'($urandom), 1'b1, 12'($urandom), 1'($urandom), wd);
         else
            cyc($urandom_range(0, 99) < pp, 8'($urandom), 1'b0, A_BYTE, 1'b0, wd);
      end

      while (q.size() > 0) pop_rd();
      stat_wr(32'h0004_0008);
      for (int i = 0; i < 5; i++) push_b(8'($urandom));
      chk("pre_reset_irq", 32'(irq), 32'h1);
      chk("pre_reset_count", 32'(count), 32'd5);
      #2;
      reset_i = 1'b0;
      #1;
      chk("async_have_data", 32'(have_data), 32'h0);
      chk("async_irq", 32'(irq), 32'h0);
      chk("async_count", 32'(count), 32'h0);
      model_reset();
      @(negedge clk_i);
      reset_i = 1'b1;
      pop_rd();
      chk("post_reset_pop", last_csr, 32'h0);
      stat_rd();
      chk("post_reset_status", last_csr, 32'h0001_0000);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
